// File: rtl/fdtd_field_buffer.sv
// Multi-bank FDTD field storage: one write port, one registered read port, and a
// clear sequencer that zeroes every bank in parallel after reset or on request.
module fdtd_field_buffer #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int NUM_BANKS         = 2,
  parameter int BANK_SEL_WIDTH    = 1,
  parameter int RD_BYPASS         = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         clr_req,
  output logic                         clr_busy,
  input  logic                         wr_en,
  input  logic [BANK_SEL_WIDTH-1:0]    wr_bank,
  input  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr,
  input  logic [FDTD_DATA_WIDTH-1:0]   wr_data,
  input  logic                         rd_en,
  input  logic [BANK_SEL_WIDTH-1:0]    rd_bank,
  input  logic [BUFFER_ADDR_WIDTH-1:0] rd_addr,
  output logic [FDTD_DATA_WIDTH-1:0]   rd_data,
  output logic                         rd_valid
);

  localparam int DEPTH = 2 ** BUFFER_ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                       state, state_nxt;
  logic [BUFFER_ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_busy    = (state == ST_CLEAR);
    case (state)
      ST_CLEAR: begin
        // Counter wraps to 0 on the last word, ready for the next clear.
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == BUFFER_ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Port qualification: all user traffic is blocked while the clear runs.
  logic wr_ok, rd_ok, rd_bank_ok, collide;

  assign wr_ok      = !clr_busy && wr_en && (int'(wr_bank) < NUM_BANKS);
  assign rd_ok      = !clr_busy && rd_en;
  assign rd_bank_ok = (int'(rd_bank) < NUM_BANKS);
  assign collide    = wr_ok && (wr_bank == rd_bank) && (wr_addr == rd_addr);

  logic [FDTD_DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [FDTD_DATA_WIDTH-1:0]   mem [DEPTH];
    logic [FDTD_DATA_WIDTH-1:0]   q;
    logic                         we;
    logic [BUFFER_ADDR_WIDTH-1:0] wa;
    logic [FDTD_DATA_WIDTH-1:0]   wd;

    assign we = clr_busy || (wr_ok && (wr_bank == BANK_SEL_WIDTH'(b)));
    assign wa = clr_busy ? clr_cnt : wr_addr;
    assign wd = clr_busy ? '0 : wr_data;

    always_ff @(posedge CLK) begin
      if (we) mem[wa] <= wd;
    end

    // Read-first synchronous read; only the addressed bank updates its output.
    always_ff @(posedge CLK) begin
      if (rd_ok && (rd_bank == BANK_SEL_WIDTH'(b))) q <= mem[rd_addr];
    end

    assign bank_dout[b] = q;
  end

  // Output steering registers; rd_zero also masks the unreset RAM outputs.
  logic [BANK_SEL_WIDTH-1:0]  rd_sel;
  logic                       rd_zero;
  logic                       rd_byp;
  logic [FDTD_DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_sel   <= '0;
      rd_zero  <= 1'b1;
      rd_byp   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_sel  <= rd_bank;
        rd_zero <= !rd_bank_ok;
        rd_byp  <= (RD_BYPASS != 0) && collide;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_ok) byp_data <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    if (rd_zero)     rd_data = '0;
    else if (rd_byp) rd_data = byp_data;
    else             rd_data = bank_dout[rd_sel];
  end

endmodule
